// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared types and constants for the nibble-serial adder controller
package seq_add_pkg;

  // Width of the reused adder slice; the operand is walked one slice per RUN cycle.
  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_add_ctrl_if.sv
// rtl/seq_add_ctrl_if.sv - request/response handshake bundle for seq_add_ctrl
interface seq_add_ctrl_if #(
  parameter int WIDTH = 32
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  // Requester / consumer side.
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  // Controller side.
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/CSA4.sv
// rtl/CSA4.sv - 4-bit carry-select adder used as the combinational slice
module CSA4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  // Low pair ripples from cin; high pair is precomputed for both carries and selected.
  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  assign lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
  assign hi0 = {1'b0, a[3:2]} + {1'b0, b[3:2]};
  assign hi1 = {1'b0, a[3:2]} + {1'b0, b[3:2]} + 3'd1;

  assign sum  = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
  assign cout = lo[2] ? hi1[2] : hi0[2];

endmodule

// File: rtl/seq_add_ctrl.sv
// rtl/seq_add_ctrl.sv - WIDTH-bit adder built by iterating one 4-bit slice, LS nibble first
module seq_add_ctrl
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  seq_add_ctrl_if.slave bus
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [KW-1:0]    k;
  logic             carry;
  logic             cout_q;
  logic             ovf_q;

  logic             accept;
  logic             last;
  logic             in_ready_c;
  logic             out_valid_c;

  logic [KW+1:0]      base;
  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;

  // Bit offset of the nibble being processed this cycle (k * 4).
  assign base    = {k, 2'b00};
  assign slice_a = a_q[base +: SLICE_W];
  assign slice_b = b_q[base +: SLICE_W];
  assign last    = (k == K_LAST);

  CSA4 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; ready only in IDLE, valid only in DONE.
  always_comb begin
    state_next  = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    accept      = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture and per-nibble accumulation; flags are latched on the final slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      k      <= '0;
      carry  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (accept) begin
      a_q   <= bus.a;
      b_q   <= bus.b;
      carry <= bus.cin;
      k     <= '0;
    end else if (state == RUN) begin
      sum_q[base +: SLICE_W] <= slice_sum;
      carry                  <= slice_cout;
      if (last) begin
        k      <= '0;
        cout_q <= slice_cout;
        // Carry into the MSB is recovered as a^b^sum at that bit, then XORed with cout.
        ovf_q  <= slice_a[SLICE_W-1] ^ slice_b[SLICE_W-1] ^ slice_sum[SLICE_W-1] ^ slice_cout;
      end else begin
        k <= k + KW'(1);
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: doc/seq_add_ctrl.md
SEQ_ADD_CTRL -- requirements
Module: seq_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand width in bits; a multiple of 4 and at least 4.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port: in_valid  input  1  operand request valid.
REQ-005 SHALL have port: in_ready  output  1  controller can accept a request.
REQ-006 SHALL have port: a  input  WIDTH  operand A.
REQ-007 SHALL have port: b  input  WIDTH  operand B.
REQ-008 SHALL have port: cin  input  1  carry-in.
REQ-009 SHALL have port: out_valid  output  1  result valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port: sum  output  WIDTH  registered result a+b+cin, modulo 2^WIDTH.
REQ-012 SHALL have port: cout  output  1  carry out of bit WIDTH-1.
REQ-013 SHALL have port: ovf  output  1  two's-complement overflow: carry into MSB XOR cout.

Function
REQ-014 SHALL compute the WIDTH-bit sum by reusing one 4-bit adder slice over NSLICE = WIDTH/4 cycles, least-significant nibble first.
REQ-015 SHALL implement states IDLE, RUN, DONE.
REQ-016 IDLE: in_ready=1; on in_valid=1, capture a, b and cin into internal registers, clear slice counter k, go to RUN.
REQ-017 RUN: each cycle, apply captured bits [4k+3:4k] and the carry register to the slice, store the slice sum into sum[4k+3:4k], load the slice carry into the carry register, increment k.
REQ-018 RUN: in the cycle k = NSLICE-1, also register cout from the slice carry and ovf, then go to DONE.
REQ-019 WIDTH=4: RUN SHALL last exactly one cycle.
REQ-020 DONE: out_valid=1; sum, cout and ovf held stable; on out_ready=1 go to IDLE.
REQ-021 Latency: out_valid SHALL rise NSLICE+1 cycles after the accepting edge; throughput is one operation per NSLICE+2 cycles minimum.
REQ-022 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes there SHALL be ignored, and captured operands stay unchanged.
REQ-023 No accept in the DONE->IDLE handoff cycle; in_ready SHALL reassert the cycle after out_valid&&out_ready.
REQ-024 out_ready held 0 SHALL keep DONE indefinitely with all outputs unchanged.
REQ-025 The slice counter SHALL be ceil(log2(NSLICE)) bits wide, minimum 1, and SHALL never exceed NSLICE-1.

Reset
REQ-026 With rst_n=0 at a rising edge: state=IDLE, k=0, carry register=0, sum=0, cout=0, ovf=0, out_valid=0; in_ready SHALL be 1 from the first cycle after reset.
REQ-027 Reset during RUN or DONE SHALL abandon the operation with no out_valid pulse.

Structure
REQ-028 SHALL place the state enumeration and the SLICE_W=4 constant in shared package seq_add_pkg.
REQ-029 SHALL instantiate the existing 4-bit carry-select adder CSA4 as its only sub-module, used as the combinational slice.
REQ-030 SHALL NOT use a WIDTH-bit "+" operator anywhere in its datapath.

Verification
REQ-031 a=0xFFFFFFFF, b=0x00000001, cin=0 -> sum=0x00000000, cout=1, ovf=0; out_valid exactly 9 cycles after accept.
REQ-032 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-033 a=0x12345678, b=0x9ABCDEF0, cin=1, out_ready=0 for 5 cycles -> sum=0xACF13569, cout=0, stable throughout; return to IDLE one cycle after out_ready=1.
REQ-034 in_valid held high with new operands during RUN -> first result unaffected; second op accepted only after in_ready reasserts.
REQ-035 rst_n=0 at RUN cycle 3 -> IDLE next cycle, no out_valid pulse, outputs 0; a following op 0x00000005+0x00000003 gives 0x00000008.
REQ-036 WIDTH=4: 0xF+0x1, cin=1 -> sum=0x1, cout=1, out_valid 2 cycles after accept.
